// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 key schedule sequencer.
// The S-box is computed as inverse-then-affine so no 256-entry table has to be maintained by hand.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    // b^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key expansion step: RotWord, SubWord and Rcon applied to w3,
// followed by the XOR chain across w0..w3. Purely combinational.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_w3[gi*8 +: 8] = sbox(rot_w3[gi*8 +: 8]);
    end
  endgenerate

  assign temp = sub_w3 ^ {rcon, 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: emits round keys 0..NR over valid/ready.
// Optional last_key_o port (decryption start key) is enabled by AES_KEYSCHED_LASTKEY_EN.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         done_o
`ifdef AES_KEYSCHED_LASTKEY_EN
  ,
  output logic [127:0] last_key_o
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next, step_key;
  logic [3:0]   idx_reg, idx_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic         xfer;

  aes_key_expand_step u_step (
    .key      (key_reg),
    .rcon     (rcon_reg),
    .next_key (step_key)
  );

  assign xfer = (state_reg == EXPAND) && rk_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
      rcon_reg  <= RCON_INIT;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      idx_reg   <= idx_next;
      rcon_reg  <= rcon_next;
    end
  end

  // Registers hold unless a start is taken or a non-final transfer advances the schedule
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    idx_next   = idx_reg;
    rcon_next  = rcon_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = EXPAND;
          key_next   = key_i;
          idx_next   = '0;
          rcon_next  = RCON_INIT;
        end
      end
      EXPAND: begin
        if (xfer) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            key_next  = step_key;
            idx_next  = idx_reg + 4'd1;
            rcon_next = xtime(rcon_reg);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = 1'b0;
    rk_valid_o = 1'b0;
    done_o     = 1'b0;
    case (state_reg)
      EXPAND: begin
        busy_o     = 1'b1;
        rk_valid_o = 1'b1;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign rk_o     = key_reg;
  assign rk_idx_o = idx_reg;

`ifdef AES_KEYSCHED_LASTKEY_EN
  logic [127:0] last_key_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_key_reg <= '0;
    end else if (xfer && (idx_reg == LAST_IDX)) begin
      last_key_reg <= key_reg;
    end
  end

  assign last_key_o = last_key_reg;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: a FIPS-197 style word-array key expansion model
// checked every cycle, plus directed FIPS-197 vectors pinning both model and DUT.
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ALT_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b1;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic [127:0] rk;
  logic [3:0]   idx;
  logic [127:0] last_key;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_keys [0:10];
  bit           m_active = 1'b0;
  bit           m_done = 1'b0;
  bit           m_fresh = 1'b1;
  int           m_idx = 0;
  logic [127:0] m_last = '0;

  aes_key_sched_ctrl #(.NR(NR)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .key_i      (key_in),
    .busy_o     (busy),
    .rk_valid_o (rk_valid),
    .rk_ready_i (ready),
    .rk_o       (rk),
    .rk_idx_o   (idx),
    .done_o     (done)
`ifdef AES_KEYSCHED_LASTKEY_EN
    ,
    .last_key_o (last_key)
`endif
  );

`ifndef AES_KEYSCHED_LASTKEY_EN
  assign last_key = '0;
`endif

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  // Brute-force inverse search plus bitwise affine transform
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
               inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sb[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {RCON_TAB[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference model: advances on the same edges as the DUT from sampled inputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_idx    = 0;
      m_fresh  = 1'b1;
      m_last   = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (ready) begin
        $display("xfer idx=%0d rk=%h", m_idx, m_keys[m_idx]);
        if (m_idx == NR) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_last   = m_keys[NR];
        end else begin
          m_idx++;
        end
      end
    end else if (start) begin
      model_expand(key_in);
      m_active = 1'b1;
      m_idx    = 0;
      m_fresh  = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("busy", 128'(busy), 128'(m_active | m_done));
    check("rk_valid", 128'(rk_valid), 128'(m_active));
    check("done", 128'(done), 128'(m_done));
    if (m_active) begin
      check("rk", rk, m_keys[m_idx]);
      check("rk_idx", 128'(idx), 128'(m_idx));
    end else if (m_fresh) begin
      check("rk_reset", rk, '0);
      check("rk_idx_reset", 128'(idx), '0);
    end
`ifdef AES_KEYSCHED_LASTKEY_EN
    check("last_key", last_key, m_last);
`endif
  end

  task automatic start_run(input logic [127:0] k);
    @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = ~k;
  endtask

  task automatic wait_idx(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rk_valid && idx == 4'(k)) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_idx", 128'(ok), 128'(1));
  endtask

  task automatic finish_run(input bit chk10, input logic [127:0] exp10);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (chk10 && rk_valid && idx == 4'(NR)) check("rk_last_literal", rk, exp10);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 128'(seen), 128'(1));
  endtask

  initial begin
    int done_cyc;
    logic [127:0] hold;

    build_sbox();
    model_expand(FIPS_KEY);
    check("model_rk0", m_keys[0], FIPS_KEY);
    check("model_rk1", m_keys[1], FIPS_RK1);
    check("model_rk10", m_keys[10], FIPS_RK10);
    model_expand('0);
    check("model_zero_rk1", m_keys[1], ZERO_RK1);

    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 128'(busy), '0);
    check("reset_valid", 128'(rk_valid), '0);
    check("reset_done", 128'(done), '0);
    check("reset_rk", rk, '0);
    check("reset_idx", 128'(idx), '0);
    check("reset_last_key", last_key, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // FIPS key, ready held high, cycle-exact latency
    start_run(FIPS_KEY);
    done_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) check("fips_idx0", rk, FIPS_KEY);
      if (i == 2) check("fips_idx1", rk, FIPS_RK1);
      if (i == 11) check("fips_idx10", rk, FIPS_RK10);
      if (done) begin
        done_cyc = i;
        break;
      end
    end
    check("done_cycle", 128'(done_cyc), 128'(NR + 2));
`ifdef AES_KEYSCHED_LASTKEY_EN
    repeat (3) begin
      @(negedge clk);
      check("last_key_hold", last_key, FIPS_RK10);
    end
`endif

    // Backpressure on idx4
    start_run(FIPS_KEY);
    wait_idx(4);
    ready = 1'b0;
    hold  = rk;
    repeat (3) begin
      @(negedge clk);
      check("stall_rk", rk, hold);
      check("stall_idx", 128'(idx), 128'(4));
      check("stall_valid", 128'(rk_valid), 128'(1));
    end
    ready = 1'b1;
    finish_run(1'b1, FIPS_RK10);

    // Start during EXPAND with a different key is ignored
    start_run(FIPS_KEY);
    wait_idx(3);
    start  = 1'b1;
    key_in = ALT_KEY;
    @(negedge clk);
    start = 1'b0;
    finish_run(1'b1, FIPS_RK10);

    // Reset mid-expansion, then restart
    start_run(FIPS_KEY);
    wait_idx(5);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 128'(busy), '0);
    check("midreset_valid", 128'(rk_valid), '0);
    check("midreset_done", 128'(done), '0);
    check("midreset_rk", rk, '0);
    check("midreset_idx", 128'(idx), '0);
    check("midreset_last_key", last_key, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midreset_no_done", 128'(done), '0);
    end
    start_run(FIPS_KEY);
    @(negedge clk);
    check("restart_idx0_rk", rk, FIPS_KEY);
    check("restart_idx0_idx", 128'(idx), '0);
    finish_run(1'b1, FIPS_RK10);

    // All-zero key
    start_run('0);
    @(negedge clk);
    check("zero_idx0", rk, '0);
    @(negedge clk);
    check("zero_idx1", rk, ZERO_RK1);
    check("zero_idx1_idx", 128'(idx), 128'(1));
    finish_run(1'b0, '0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
